cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Registered arbiter between the 8 functional units and the 3-wide CDB/complete path.
- Each FU has a one-entry result holding register. Up to 3 held results are granted per cycle using rotating (round-robin) priority.
- Granted results drive the PR-write, ROB-complete and precise-state outputs. FUs that are not granted are back-pressured, so no result is ever dropped.
- Starvation-free; replaces the fixed-priority first-3 selection at the complete stage.

Parameters:
- NUM_FU, 8, number of requesting functional units; equals the FU_STATE_PACKET width.
- NUM_CDB, 3, broadcast slots per cycle.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- squash  in  1  mispredict/precise-state flush; discards all held results
- fu_finish  in  FU_STATE_PACKET (NUM_FU)  per-FU result-valid request
- fu_c_in  in  FU_COMPLETE_PACKET [NUM_FU-1:0]  per-FU result: dest_pr, dest_value, rob_entry, if_take_branch, target_pc
- fu_ready  out  FU_STATE_PACKET (NUM_FU)  holding register can accept this cycle
- cdb_t  out  CDB_T_PACKET  destination PRs t0..t2; 0 means no write
- wb_value  out  [2:0][XLEN-1:0]  write-back values; 0 when slot invalid
- complete_valid  out  [2:0]  ROB-complete strobe per slot
- complete_entry  out  [2:0][ROB-1:0]  ROB index per slot
- precise_state_valid  out  [2:0]  slot holds a taken branch
- target_pc  out  [2:0][XLEN-1:0]  redirect PC; 0 unless precise_state_valid

Behaviour:
- Registers:
  - occ[NUM_FU]: holding register occupied.
  - hold[NUM_FU]: FU_COMPLETE_PACKET.
  - rr_ptr: $clog2(NUM_FU) bits.
- Reset (asynchronous): occ=0, hold=0, rr_ptr=0. All outputs are combinational from these registers, so they read 0 during reset.
- Accept (handshake):
  - fu_ready[i] = ~occ[i] | grant[i]. A granted entry can be refilled in the same cycle.
  - On a clock edge with fu_finish[i] & fu_ready[i] & ~squash: hold[i] <= fu_c_in[i], occ[i] <= 1.
  - fu_finish[i] while fu_ready[i]=0 is a stall. The FU must hold its request and data stable; the arbiter ignores the data.
- Grant:
  - Scan occ circularly starting at rr_ptr.
  - The first three occupied indices become grant1, grant2, grant3.
  - grant = OR of the three one-hot vectors.
- Slot mapping (downstream convention): grant1 → slot 2, grant2 → slot 1, grant3 → slot 0.
  - Each slot drives dest_pr, dest_value, rob_entry, complete_valid=1 and, if if_take_branch, precise_state_valid=1 and target_pc.
  - Slots with no grant output all zeros.
- Latency: exactly 1 cycle from accept to broadcast when uncontended. Worst-case wait is ceil(NUM_FU/NUM_CDB)-1 = 2 extra cycles.
- Release: at the edge, occ[i] <= 0 for each granted i, unless it is refilled the same cycle.
- Pointer: if grant≠0, rr_ptr <= (index of the last granted entry + 1) mod NUM_FU, with wrap 7→0. Otherwise rr_ptr is held.
- squash:
  - Same cycle: all slot outputs forced to 0 and fu_ready forced to 0.
  - Next edge: occ <= 0; rr_ptr is held.
  - squash takes priority over simultaneous accept and grant.
- Only 0–3 occupied entries: every occupied entry is granted that cycle; no slot is duplicated.
- All 8 occupied and all FUs re-requesting continuously: each FU is granted once in every 3 consecutive cycles (bounded fairness).
- dest_pr=0 results (stores, branches) still arbitrate. They drive cdb_t=0 but complete_valid=1.

Decomposition:
- Shared package (existing sys_defs): FU_STATE_PACKET, FU_COMPLETE_PACKET, CDB_T_PACKET, XLEN, ROB. Add NUM_CDB there.
- Sub-module rr_pick: rotating-priority first-one finder (req, base pointer → one-hot grant, index, valid). Instantiate it three times in cascade, masking earlier grants.
- Holding registers and the pointer live in the top module.

Test Plan:
- Reset mid-stream: occ has 5 entries set, assert reset asynchronously → outputs all 0 immediately, fu_ready=8'hFF after release, rr_ptr=0.
- Single request: fu_finish=8'b0000_0100 with dest_pr=7, value=32'hDEAD, rob=3 → next cycle slot2: cdb_t.t2=7, wb_value[2]=32'hDEAD, complete_entry[2]=3; slots 1 and 0 are zero.
- Overflow, 5 simultaneous requests FU0–4 with rr_ptr=0:
  - Cycle 1 grants FU0, FU1, FU2 (slots 2, 1, 0); fu_ready[3]=fu_ready[4]=0; rr_ptr=3.
  - Cycle 2 grants FU3 and FU4; slot 0 is invalid.
- Wrap-around: rr_ptr=6 with occ=8'b1100_0011 → grants FU6, FU7, FU0 in that order; rr_ptr becomes 1.
- Fairness: all 8 FUs request every cycle for 24 cycles → each FU receives exactly 9 grants, and no FU waits more than 3 cycles.
- Branch plus squash:
  - FU5 result has if_take_branch=1, target_pc=32'h400 → precise_state_valid=1 with target_pc=32'h400 in its slot.
  - Next cycle assert squash with 2 entries held → all outputs 0, and occ=0 the following cycle.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the complete stage: FU result packets, CDB tag packet, sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cdb_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int ROB      = 5;               // ROB index width
  localparam int PR_W     = 6;               // physical register index width
  localparam int NUM_FU   = 8;
  localparam int NUM_CDB  = 3;
  localparam int FU_IDX_W = $clog2(NUM_FU);

  typedef logic [NUM_FU-1:0] FU_STATE_PACKET;

  typedef struct packed {
    logic [PR_W-1:0] dest_pr;
    logic [XLEN-1:0] dest_value;
    logic [ROB-1:0]  rob_entry;
    logic            if_take_branch;
    logic [XLEN-1:0] target_pc;
  } FU_COMPLETE_PACKET;

  // t2 is the MSB field so the packet lines up with a [2:0][PR_W-1:0] slot vector.
  typedef struct packed {
    logic [PR_W-1:0] t2;
    logic [PR_W-1:0] t1;
    logic [PR_W-1:0] t0;
  } CDB_T_PACKET;

  // Circular successor of an FU index.
  function automatic logic [FU_IDX_W-1:0] next_fu_idx(input logic [FU_IDX_W-1:0] i);
    return (i == FU_IDX_W'(NUM_FU - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotating-priority first-one finder: first set req bit at or after base, wrapping.
// Latency: combinational.
// Backpressure: none; pure function of req and base.
module cdb_arbiter_rr_pick
  import cdb_arbiter_pkg::*;
(
  input  logic [NUM_FU-1:0]   req,
  input  logic [FU_IDX_W-1:0] base,
  output logic [NUM_FU-1:0]   gnt,
  output logic [FU_IDX_W-1:0] idx,
  output logic                vld
);

  // Walk the request vector circularly from base and keep the first hit.
  always_comb begin
    int pos;
    pos = 0;
    gnt = '0;
    idx = base;
    vld = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      pos = (int'(base) + k) % NUM_FU;
      if (!vld && req[pos]) begin
        vld      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos[FU_IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Arbitrates 8 FU result holding registers onto the 3-wide CDB/complete path, round-robin.
// Latency: 1 cycle accept-to-broadcast uncontended; at most 2 extra cycles under full load.
// Backpressure: fu_ready drops for held, ungranted entries and for every FU during squash.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           squash,
  input  FU_STATE_PACKET                 fu_finish,
  input  FU_COMPLETE_PACKET [NUM_FU-1:0] fu_c_in,
  output FU_STATE_PACKET                 fu_ready,
  output CDB_T_PACKET                    cdb_t,
  output logic [NUM_CDB-1:0][XLEN-1:0]   wb_value,
  output logic [NUM_CDB-1:0]             complete_valid,
  output logic [NUM_CDB-1:0][ROB-1:0]    complete_entry,
  output logic [NUM_CDB-1:0]             precise_state_valid,
  output logic [NUM_CDB-1:0][XLEN-1:0]   target_pc
);

  logic [NUM_FU-1:0]              occ_q, occ_d;
  FU_COMPLETE_PACKET [NUM_FU-1:0] hold_q, hold_d;
  logic [FU_IDX_W-1:0]            rr_ptr_q, rr_ptr_d;

  logic [NUM_FU-1:0]   gnt1, gnt2, gnt3, grant, accept;
  logic [FU_IDX_W-1:0] idx1, idx2, idx3, last_idx;
  logic                vld1, vld2, vld3;

  // Three cascaded pickers share the same base; each sees the earlier winners masked off.
  cdb_arbiter_rr_pick u_pick1 (.req(occ_q),                 .base(rr_ptr_q), .gnt(gnt1), .idx(idx1), .vld(vld1));
  cdb_arbiter_rr_pick u_pick2 (.req(occ_q & ~gnt1),         .base(rr_ptr_q), .gnt(gnt2), .idx(idx2), .vld(vld2));
  cdb_arbiter_rr_pick u_pick3 (.req(occ_q & ~gnt1 & ~gnt2), .base(rr_ptr_q), .gnt(gnt3), .idx(idx3), .vld(vld3));

  assign grant    = gnt1 | gnt2 | gnt3;
  // A granted entry drains this edge, so it can take a new result at the same time.
  assign fu_ready = squash ? '0 : (~occ_q | grant);
  assign accept   = fu_finish & fu_ready;
  assign last_idx = vld3 ? idx3 : (vld2 ? idx2 : idx1);

  // Drive the broadcast slots: first winner on slot 2, second on slot 1, third on slot 0.
  always_comb begin
    logic [NUM_CDB-1:0]                slot_vld;
    logic [NUM_CDB-1:0][FU_IDX_W-1:0] slot_idx;
    logic [NUM_CDB-1:0][PR_W-1:0]     slot_pr;
    FU_COMPLETE_PACKET                 ent;
    slot_vld            = {vld1, vld2, vld3};
    slot_idx            = {idx1, idx2, idx3};
    slot_pr             = '0;
    ent                 = '0;
    wb_value            = '0;
    complete_valid      = '0;
    complete_entry      = '0;
    precise_state_valid = '0;
    target_pc           = '0;
    for (int s = 0; s < NUM_CDB; s++) begin
      if (slot_vld[s] && !squash) begin
        ent               = hold_q[slot_idx[s]];
        slot_pr[s]        = ent.dest_pr;
        wb_value[s]       = ent.dest_value;
        complete_valid[s] = 1'b1;
        complete_entry[s] = ent.rob_entry;
        if (ent.if_take_branch) begin
          precise_state_valid[s] = 1'b1;
          target_pc[s]           = ent.target_pc;
        end
      end
    end
    cdb_t = CDB_T_PACKET'(slot_pr);
  end

  // Next state: release granted entries, capture accepted ones, advance past the last winner.
  always_comb begin
    occ_d    = (occ_q & ~grant) | accept;
    hold_d   = hold_q;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (accept[i]) hold_d[i] = fu_c_in[i];
    end
    if (squash) begin
      occ_d = '0;
    end else if (vld1) begin
      rr_ptr_d = next_fu_idx(last_idx);
    end
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_q    <= '0;
      hold_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      occ_q    <= occ_d;
      hold_q   <= hold_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
